// File: rtl/br_perf_monitor.sv
// br_perf_monitor: counts cycles, resolved branches and mispredictions during
// a run, detects program end from a repeated halt instruction in fetch, then
// freezes the counters and streams a four-word report over a valid/ready port.
module br_perf_monitor #(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] HALT_INSN   = 32'h0000_006F,
    parameter int          HALT_REPEAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             br_misses_i,
    input  logic             br_instr_i,
    input  logic [31:0]      instr_i,
    output logic             rpt_valid_o,
    input  logic             rpt_ready_i,
    output logic [1:0]       rpt_idx_o,
    output logic [CNT_W-1:0] rpt_data_o,
    output logic             done_o
);

    // Streak counter only needs to reach HALT_REPEAT.
    localparam int SW = (HALT_REPEAT < 2) ? 1 : $clog2(HALT_REPEAT + 1);
    localparam logic [SW-1:0] STREAK_END = SW'(HALT_REPEAT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RPT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] branches;
    logic [CNT_W-1:0] misses;
    logic [CNT_W-1:0] hits;
    logic [SW-1:0]    streak;
    logic [SW-1:0]    streak_nxt;
    logic [1:0]       idx;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end
        return v;
    endfunction

    // Next halt streak: extends on a halt fetch, restarts on anything else.
    always_comb begin
        streak_nxt = '0;
        if (instr_i == HALT_INSN) begin
            streak_nxt = streak + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // Hits clamp to zero when misses outnumber branches (miss-only strobes).
    always_comb begin
        hits = '0;
        if (branches >= misses) begin
            hits = branches - misses;
        end
    end

    // Control FSM plus counters; clear has priority over every state action.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            cycles   <= '0;
            branches <= '0;
            misses   <= '0;
            streak   <= '0;
            idx      <= '0;
        end else if (clr_i) begin
            state    <= S_IDLE;
            cycles   <= '0;
            branches <= '0;
            misses   <= '0;
            streak   <= '0;
            idx      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en_i) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (en_i) begin
                        cycles   <= sat_inc(cycles, 1'b1);
                        branches <= sat_inc(branches, br_instr_i);
                        misses   <= sat_inc(misses, br_misses_i);
                        streak   <= streak_nxt;
                        if (streak_nxt == STREAK_END) begin
                            state <= S_RPT;
                            idx   <= '0;
                        end
                    end
                end
                S_RPT: begin
                    if (rpt_ready_i) begin
                        if (idx == 2'd3) begin
                            state <= S_DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: begin
                    // DONE holds until clear or reset.
                end
            endcase
        end
    end

    // Report word select driven only from registered counters and index.
    always_comb begin
        rpt_data_o = cycles;
        case (idx)
            2'd1:    rpt_data_o = branches;
            2'd2:    rpt_data_o = misses;
            2'd3:    rpt_data_o = hits;
            default: rpt_data_o = cycles;
        endcase
    end

    assign rpt_valid_o = (state == S_RPT);
    assign done_o      = (state == S_DONE);
    assign rpt_idx_o   = idx;

endmodule

// File: doc/br_perf_monitor.md
# br_perf_monitor

Bench-side consumer of the branch-prediction probe signals exported by the pipelined core wrappers: branch-miss strobe, branch-instruction strobe and fetched instruction. It counts cycles, resolved branches and mispredictions while a run is enabled, and detects program end from a repeated halt instruction in fetch. It then freezes the counters and streams a four-word report over a valid/ready port to the bench's logger or scoreboard. It is the same block for all predictor variants (always-taken, two-bit, gshare, gshare v2, agree).

## Interface
- CNT_W, 32, width of every counter and of report data
- HALT_INSN, 32'h0000_006F, instruction word marking program end (jal x0,0 self-loop)
- HALT_REPEAT, 4, consecutive fetch cycles of HALT_INSN required to declare end (≥1)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  count enable; start/pause
- clr_i  in  1  synchronous clear, highest priority
- br_misses_i  in  1  misprediction strobe, one per cycle
- br_instr_i  in  1  resolved branch/jump strobe
- instr_i  in  32  instruction currently in fetch
- rpt_valid_o  out  1  report word valid
- rpt_ready_i  in  1  report word accepted
- rpt_idx_o  out  2  report word index
- rpt_data_o  out  CNT_W  report word value
- done_o  out  1  report fully delivered

## Operation
- States: IDLE, RUN, RPT, DONE. Reset and clr_i force IDLE.
- Reset clears all counters, the halt streak and the index. All outputs are 0 on reset.
- IDLE: when en_i=1, go to RUN on the next edge. No counting happens in that cycle.
- RUN with en_i=1, on each edge:
  - cycles increments.
  - branches increments if br_instr_i=1.
  - misses increments if br_misses_i=1. Misses and branches are counted independently; a miss without a branch strobe is still counted.
- RUN with en_i=0: all counters and the halt streak hold.
- Halt detection (only in RUN with en_i=1):
  - The streak increments when instr_i==HALT_INSN and clears to 0 otherwise.
  - When the streak reaches HALT_REPEAT, go to RPT. That cycle's events are still counted.
- All counters saturate at 2^CNT_W−1; they never wrap.
- RPT: counters are frozen and rpt_valid_o=1. Words in order:
  - idx 0: cycles
  - idx 1: branches
  - idx 2: misses
  - idx 3: hits = branches−misses, or 0 if misses > branches
- On valid&&ready, idx advances. Acceptance at idx 3 moves to DONE: valid drops and done_o=1.
- While valid=1 and ready=0, idx and data stay stable.
- DONE: holds until clr_i or reset. Inputs are ignored.
- clr_i=1 in any state: on the next edge the state returns to IDLE and all counters, streak, idx, valid and done clear. clr_i is the only legal way to drop valid before acceptance.
- Reset mid-operation: immediate asynchronous return to the reset state.

## Timing
- All outputs are registered or driven from registered state plus a mux on the registered idx. Nothing combinational passes from inputs to outputs.
- Counter update latency is one edge.
- If the halt streak completes at edge k, rpt_valid_o=1 after edge k with idx 0.
- With rpt_ready_i held at 1, the four words are delivered in 4 consecutive cycles and done_o=1 after the 4th acceptance edge.
- rpt_ready_i may be high before valid; it has no effect outside RPT.
- Simultaneous br_instr_i and br_misses_i in one cycle increment both counters.

## Test plan
- Basic run (HALT_REPEAT=4, ready=1): en_i=1, 10 non-halt fetch cycles, then 4 HALT_INSN cycles. Expect report 14, 0, 0, 0; valid for 4 cycles; then done_o=1.
- Branch counting: in RUN, 8 br_instr_i pulses, 3 of them with br_misses_i, then halt. Expect branches=8, misses=3, hits=5.
- Hits clamp (gshare-style strobes): 1 br_instr_i pulse and 2 br_misses_i-only pulses. Expect misses=2, hits=0.
- Broken halt streak and pause:
  - 3 halt fetches, 1 other fetch, then 4 halts: report only after the second streak, with cycles=8.
  - en_i low for 5 cycles mid-run adds 0 to cycles.
- Backpressure: hold ready=0 for 3 cycles at idx 1. Expect idx=1 and data stable throughout, words then delivered in order 0..3, and done_o only after idx 3 is accepted.
- Saturation and clear:
  - CNT_W=4 with 20 counted cycles reports cycles=15.
  - clr_i during RPT gives valid=0, done=0, state IDLE on the next edge; a new run then counts from 0.
